seg_scan_decoder: RTL and testbench

Reverse path of the hex-to-7-segment encoder. The block samples a time-multiplexed, active-low 7-segment bus (segment lines plus digit-select lines) and decodes each stable digit pattern back to a 4-bit hex value. It assembles one value per digit into a frame and hands the frame out over a valid/ready handshake. It is used for display loop-back checking and for scraping calculator results off the display bus.

---
 rtl/seg_scan_decoder_if.sv | 35 +++
 rtl/seg_scan_decoder.sv | 152 +++++++++++++++
 tb/tb_seg_scan_decoder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder_if
// Description : Frame output handshake bundle of the 7-segment scan decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] out_value;
    logic [NUM_DIGITS-1:0]   out_blank;
    logic [NUM_DIGITS-1:0]   out_err;
    logic                    out_valid;
    logic                    out_ready;
    logic                    overrun;

    modport master (
        output out_value,
        output out_blank,
        output out_err,
        output out_valid,
        output overrun,
        input  out_ready
    );

    modport slave (
        input  out_value,
        input  out_blank,
        input  out_err,
        input  out_valid,
        input  overrun,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder
// Description : Samples a multiplexed active-low 7-segment bus, decodes each
//               stable digit and emits complete frames over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic [6:0]            seg_n,
    input  wire logic [NUM_DIGITS-1:0] an_n,
    seg_scan_decoder_if.master         frm
);

    localparam int               c_SMP_W   = NUM_DIGITS + 7;
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [c_SMP_W-1:0]      r_prev;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_latched;
    logic [NUM_DIGITS-1:0]   r_mask;
    logic [4*NUM_DIGITS-1:0] r_stg_value;
    logic [NUM_DIGITS-1:0]   r_stg_blank;
    logic [NUM_DIGITS-1:0]   r_stg_err;

    logic [c_SMP_W-1:0]      w_cur;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic                    w_onehot;
    logic                    w_same;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    w_capture;
    logic [3:0]              w_dec_value;
    logic                    w_dec_blank;
    logic                    w_dec_err;
    logic                    w_full;
    logic                    w_xfer;
    logic                    w_load;
    logic                    w_drop;

    assign w_cur    = {an_n, seg_n};
    assign w_sel    = ~an_n;
    assign w_onehot = (w_sel != '0) && ((w_sel & (w_sel - NUM_DIGITS'(1))) == '0);
    assign w_same   = (w_cur == r_prev) && w_onehot;

    always_comb begin
        w_cnt_nxt = '0;
        if (w_same) begin
            w_cnt_nxt = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        end
    end

    // Count reaching its ceiling means this is the STABLE_CYCLES-th identical sample.
    assign w_capture = w_same && (w_cnt_nxt == c_CNT_MAX) && !r_latched;

    always_comb begin
        w_dec_value = 4'h0;
        w_dec_blank = 1'b0;
        w_dec_err   = 1'b0;
        case (seg_n)
            7'b1000000: w_dec_value = 4'h0;
            7'b1111001: w_dec_value = 4'h1;
            7'b0100100: w_dec_value = 4'h2;
            7'b0110000: w_dec_value = 4'h3;
            7'b0011001: w_dec_value = 4'h4;
            7'b0010010: w_dec_value = 4'h5;
            7'b0000010: w_dec_value = 4'h6;
            7'b1111000: w_dec_value = 4'h7;
            7'b0000000: w_dec_value = 4'h8;
            7'b0010000: w_dec_value = 4'h9;
            7'b0001000: w_dec_value = 4'hA;
            7'b0000011: w_dec_value = 4'hB;
            7'b1000110: w_dec_value = 4'hC;
            7'b0100001: w_dec_value = 4'hD;
            7'b0000110: w_dec_value = 4'hE;
            7'b0001110: w_dec_value = 4'hF;
            7'b1111111: w_dec_blank = 1'b1;
            default:    w_dec_err   = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev    <= '0;
            r_cnt     <= '0;
            r_latched <= 1'b0;
        end else begin
            r_prev    <= w_cur;
            r_cnt     <= w_cnt_nxt;
            r_latched <= w_same && (r_latched || w_capture);
        end
    end

    // A full mask is seen one cycle after the final capture; frame leaves from staging then.
    assign w_full = &r_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask      <= '0;
            r_stg_value <= '0;
            r_stg_blank <= '0;
            r_stg_err   <= '0;
        end else begin
            if (w_full) begin
                r_mask <= w_capture ? w_sel : '0;
            end else if (w_capture) begin
                r_mask <= r_mask | w_sel;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_capture && w_sel[i]) begin
                    r_stg_value[4*i +: 4] <= w_dec_value;
                    r_stg_blank[i]        <= w_dec_blank;
                    r_stg_err[i]          <= w_dec_err;
                end
            end
        end
    end

    assign w_xfer = frm.out_valid && frm.out_ready;
    assign w_load = w_full && (!frm.out_valid || frm.out_ready);
    assign w_drop = w_full && !w_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm.out_value <= '0;
            frm.out_blank <= '0;
            frm.out_err   <= '0;
            frm.out_valid <= 1'b0;
            frm.overrun   <= 1'b0;
        end else begin
            if (w_load) begin
                frm.out_value <= r_stg_value;
                frm.out_blank <= r_stg_blank;
                frm.out_err   <= r_stg_err;
                frm.out_valid <= 1'b1;
            end else if (w_xfer) begin
                frm.out_valid <= 1'b0;
            end
            if (w_drop) begin
                frm.overrun <= 1'b1;
            end else if (w_xfer) begin
                frm.overrun <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_decoder
// Description : Directed bench with a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    seg_n = 7'h7F;
    logic [ND-1:0] an_n  = '1;

    seg_scan_decoder_if #(.NUM_DIGITS(ND)) frm_if ();

    seg_scan_decoder #(
        .NUM_DIGITS   (ND),
        .STABLE_CYCLES(SC),
        .CNT_W        (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .seg_n(seg_n),
        .an_n (an_n),
        .frm  (frm_if)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [6:0] pat [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    task automatic decode(input logic [6:0] s, output logic [3:0] v, output bit b, output bit e);
        v = 4'h0;
        b = 1'b0;
        e = 1'b1;
        if (s == 7'h7F) begin
            b = 1'b1;
            e = 1'b0;
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (pat[k] == s) begin
                    v = k[3:0];
                    e = 1'b0;
                end
            end
        end
    endtask

    // Reference model: run length of identical valid samples, per-digit slots, pending frame.
    int              run = 0;
    logic [ND+6:0]   last = '0;
    logic [3:0]      slot_v [ND];
    bit              slot_b [ND];
    bit              slot_e [ND];
    bit              got    [ND];
    bit              pend = 1'b0;
    logic [4*ND-1:0] pend_v;
    logic [ND-1:0]   pend_b, pend_e;
    logic [4*ND-1:0] m_value = '0;
    logic [ND-1:0]   m_blank = '0;
    logic [ND-1:0]   m_err   = '0;
    bit              m_valid = 1'b0;
    bit              m_ovr   = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            run = 0; last = '0; pend = 1'b0;
            m_value = '0; m_blank = '0; m_err = '0; m_valid = 1'b0; m_ovr = 1'b0;
            for (int i = 0; i < ND; i++) begin
                got[i] = 1'b0; slot_v[i] = 4'h0; slot_b[i] = 1'b0; slot_e[i] = 1'b0;
            end
        end else begin
            automatic bit xfer = m_valid && frm_if.out_ready;
            automatic bit sel_ok = ($countones(an_n) == ND - 1);
            automatic logic [ND+6:0] cur = {an_n, seg_n};
            if (pend) begin
                if (!m_valid || frm_if.out_ready) begin
                    m_value = pend_v; m_blank = pend_b; m_err = pend_e; m_valid = 1'b1;
                    if (xfer) m_ovr = 1'b0;
                end else begin
                    m_ovr = 1'b1;
                end
                pend = 1'b0;
            end else if (xfer) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
            if (sel_ok && cur == last) run++;
            else run = sel_ok ? 1 : 0;
            last = cur;
            if (run == SC) begin
                automatic int idx = 0;
                automatic bit all = 1'b1;
                for (int i = 0; i < ND; i++) if (!an_n[i]) idx = i;
                decode(seg_n, slot_v[idx], slot_b[idx], slot_e[idx]);
                got[idx] = 1'b1;
                for (int i = 0; i < ND; i++) all = all && got[i];
                if (all) begin
                    pend = 1'b1;
                    for (int i = 0; i < ND; i++) begin
                        pend_v[4*i +: 4] = slot_v[i];
                        pend_b[i] = slot_b[i];
                        pend_e[i] = slot_e[i];
                        got[i] = 1'b0;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("value",   64'(frm_if.out_value), 64'(m_value));
        check("blank",   64'(frm_if.out_blank), 64'(m_blank));
        check("err",     64'(frm_if.out_err),   64'(m_err));
        check("valid",   64'(frm_if.out_valid), 64'(m_valid));
        check("overrun", 64'(frm_if.overrun),   64'(m_ovr));
    end

    // Records each new frame (rising out_valid) for the literal checks.
    int              frames = 0;
    logic [4*ND-1:0] last_v = '0;
    logic [ND-1:0]   last_b = '0, last_e = '0;
    bit              pv = 1'b0;

    always @(posedge clk) begin
        #1;
        if (frm_if.out_valid && !pv) begin
            frames++;
            last_v = frm_if.out_value;
            last_b = frm_if.out_blank;
            last_e = frm_if.out_err;
        end
        pv = frm_if.out_valid;
    end

    task automatic show_raw(input logic [ND-1:0] an, input logic [6:0] s, input int n);
        @(negedge clk);
        an_n  = an;
        seg_n = s;
        repeat (n) @(posedge clk);
    endtask

    task automatic show(input int d, input logic [6:0] s, input int n);
        logic [ND-1:0] one = 1;
        show_raw(~(one << d), s, n);
    endtask

    initial begin
        frm_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_value", 64'(frm_if.out_value), 64'h0);
        check("rst_valid", 64'(frm_if.out_valid), 64'h0);
        check("rst_ovr",   64'(frm_if.overrun),   64'h0);
        rst_n = 1'b1;

        // Basic frame 4321
        for (int d = 0; d < ND; d++) show(d, pat[d+1], 6);
        @(negedge clk);
        check("s1_frames", 64'(frames), 64'd1);
        check("s1_value",  64'(last_v), 64'h4321);
        check("s1_blank",  64'(last_b), 64'h0);
        check("s1_err",    64'(last_e), 64'h0);

        // Short dwell on digit 1 does not capture
        show(0, pat[5], 6);
        show(1, pat[6], SC - 1);
        show(2, pat[7], 6);
        show(3, pat[8], 6);
        @(negedge clk);
        check("s2_noframe", 64'(frames), 64'd1);
        show(1, pat[6], 6);
        @(negedge clk);
        check("s2_frames", 64'(frames), 64'd2);
        check("s2_value",  64'(last_v), 64'h8765);

        // Blank and unmapped patterns
        show(0, pat[0], 6);
        show(1, 7'b0101010, 6);
        show(2, 7'b1111111, 6);
        show(3, pat[15], 6);
        @(negedge clk);
        check("s3_value", 64'(last_v), 64'hF000);
        check("s3_blank", 64'(last_b), 64'b0100);
        check("s3_err",   64'(last_e), 64'b0010);

        // Back-pressure: second frame dropped
        frm_if.out_ready = 1'b0;
        for (int d = 0; d < ND; d++) show(d, pat[9+d], 6);
        show(0, pat[13], 6);
        show(1, pat[14], 6);
        show(2, pat[15], 6);
        show(3, pat[0], 6);
        @(negedge clk);
        check("s4_valid", 64'(frm_if.out_valid), 64'h1);
        check("s4_value", 64'(frm_if.out_value), 64'hCBA9);
        check("s4_ovr",   64'(frm_if.overrun),   64'h1);
        check("s4_frames", 64'(frames), 64'd4);
        frm_if.out_ready = 1'b1;
        @(negedge clk);
        frm_if.out_ready = 1'b0;
        check("s4_valid_clr", 64'(frm_if.out_valid), 64'h0);
        check("s4_ovr_clr",   64'(frm_if.overrun),   64'h0);

        // Double select, then reset mid-frame
        frm_if.out_ready = 1'b1;
        show_raw(4'b0011, pat[1], 10);
        show(0, pat[1], 6);
        show(1, pat[2], 6);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("s5_rst_value", 64'(frm_if.out_value), 64'h0);
        check("s5_rst_valid", 64'(frm_if.out_valid), 64'h0);
        check("s5_rst_blank", 64'(frm_if.out_blank), 64'h0);
        check("s5_rst_err",   64'(frm_if.out_err),   64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        show(2, pat[3], 6);
        show(3, pat[4], 6);
        @(negedge clk);
        check("s5_noframe", 64'(frames), 64'd4);
        show(0, pat[5], 6);
        show(1, pat[6], 6);
        @(negedge clk);
        check("s5_frames", 64'(frames), 64'd5);
        check("s5_value",  64'(last_v), 64'h4365);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
